// File: rtl/status_uart_pkg.sv
// Shared types and constants for the status-line UART transmitter.
// Imported by the frame sequencer and the byte serialiser.
package status_uart_pkg;

    localparam int FRAME_LEN = 11;

    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;

    // Serialiser states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Frame sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FEED,
        SEQ_LAST,
        SEQ_DONE
    } seq_t;

    typedef struct packed {
        logic       done;
        logic [7:0] tm;
        logic [7:0] tl;
        logic [7:0] sm;
        logic [7:0] sl;
    } snap_t;

    localparam snap_t SNAP_RESET = '{
        done: 1'b0,
        tm:   ASCII_0,
        tl:   ASCII_0,
        sm:   ASCII_0,
        sl:   ASCII_0
    };

    function automatic logic [7:0] frame_byte(
        input logic [3:0] idx,
        input snap_t      s
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = s.done ? ASCII_D : ASCII_T;
            4'd1:    b = ASCII_EQ;
            4'd2:    b = s.tm;
            4'd3:    b = s.tl;
            4'd4:    b = ASCII_SP;
            4'd5:    b = ASCII_S;
            4'd6:    b = ASCII_EQ;
            4'd7:    b = s.sm;
            4'd8:    b = s.sl;
            4'd9:    b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/status_uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready byte input.
// Ready is offered in idle and in the last stop-bit cycle so bytes chain gaplessly.
module uart_tx_byte
    import status_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end  = (r_cnt == LAST);
    assign byte_ready = (r_state == IDLE) ||
                        ((r_state == STOP) && w_bit_end);
    assign tx         = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (byte_valid) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_shift <= byte_data;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (byte_valid) begin
                            r_state <= START;
                            r_shift <= byte_data;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/status_uart_tx.sv
// Snapshots timer/score digits and sends one 11-byte status line over UART.
// Holds the snapshot, the byte mux and the frame sequencer.
module status_uart_tx
    import status_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] time_msb_ascii,
    input  logic [7:0] time_lsb_ascii,
    input  logic [7:0] score_msb_ascii,
    input  logic [7:0] score_lsb_ascii,
    input  logic       timer_done,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    seq_t       r_seq;
    snap_t      r_snap;
    logic [3:0] r_idx;
    logic       r_pending;
    logic       r_busy;
    logic       r_frame_done;

    snap_t      w_live;
    logic       w_restart;
    logic       w_valid;
    logic [7:0] w_data;
    logic       w_ready;
    logic       w_accept;

    assign w_live = {timer_done, time_msb_ascii, time_lsb_ascii,
                     score_msb_ascii, score_lsb_ascii};

    // Restarting from DONE feeds byte 0 straight from the live inputs,
    // so the next start bit follows the DONE cycle with no extra gap.
    assign w_restart = (r_seq == SEQ_DONE) && (r_pending || send);
    assign w_valid   = (r_seq == SEQ_FEED) || w_restart;
    assign w_data    = (r_seq == SEQ_DONE) ? frame_byte(4'd0, w_live)
                                           : frame_byte(r_idx, r_snap);
    assign w_accept  = w_valid && w_ready;

    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (w_valid),
        .byte_data  (w_data),
        .byte_ready (w_ready),
        .tx         (tx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq        <= SEQ_IDLE;
            r_snap       <= SNAP_RESET;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_seq)
                SEQ_IDLE: begin
                    if (send) begin
                        r_snap <= w_live;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        r_seq  <= SEQ_FEED;
                    end
                end
                SEQ_FEED: begin
                    if (send) r_pending <= 1'b1;
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) r_seq <= SEQ_LAST;
                        else                   r_idx <= r_idx + 1'b1;
                    end
                end
                SEQ_LAST: begin
                    if (send) r_pending <= 1'b1;
                    if (w_ready) begin
                        r_seq        <= SEQ_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    r_pending <= 1'b0;
                    if (w_restart) begin
                        r_snap <= w_live;
                        r_idx  <= 4'd1;
                        r_seq  <= SEQ_FEED;
                    end else begin
                        r_busy <= 1'b0;
                        r_seq  <= SEQ_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
